// File: rtl/imem_responder_if.sv
// Fetch-side request/response bundle between the processor fetch stage
// (master) and the instruction memory responder (slave).
interface imem_responder_if;
   logic        imemreq_val;
   logic [31:0] imemreq_addr;
   logic        imemresp_val;
   logic [31:0] imemresp_data;

   modport master (
      output imemreq_val,
      output imemreq_addr,
      input  imemresp_val,
      input  imemresp_data
   );

   modport slave (
      input  imemreq_val,
      input  imemreq_addr,
      output imemresp_val,
      output imemresp_data
   );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed array preloaded through a
// dedicated load port, answering every fetch after LATENCY cycles with a
// sticky error flag for out-of-range or misaligned fetch addresses.
// Optional feature macro: IMEM_REQ_COUNT_EN adds an accepted-request counter
// on req_count; without it req_count is tied to zero.
module imem_responder #(
   parameter int WORDS   = 256,
   parameter int LATENCY = 0
) (
   input  logic                clk,
   input  logic                rst,
   imem_responder_if.slave     imem,
   input  logic                load_en,
   input  logic [31:0]         load_addr,
   input  logic [31:0]         load_data,
   output logic                err,
   output logic [31:0]         req_count
);

   localparam int AW = $clog2(WORDS);

   // NOTE: the instruction array has no reset so a preload survives rst and
   // the storage can map onto plain RAM.
   logic [31:0] mem_q [WORDS];

   logic [AW-1:0] req_idx;
   logic          req_in_range;
   logic          req_misaligned;
   logic          req_acc;
   logic [31:0]   req_data;
   logic [AW-1:0] load_idx;
   logic          load_in_range;
   logic          unused_load_lsbs;
   logic          err_q;
   logic          err_d;

   // Requests presented while in reset are dropped entirely.
   assign req_acc          = imem.imemreq_val & ~rst;
   assign req_idx          = imem.imemreq_addr[AW+1:2];
   assign req_in_range     = (imem.imemreq_addr[31:AW+2] == '0);
   assign req_misaligned   = |imem.imemreq_addr[1:0];
   assign load_idx         = load_addr[AW+1:2];
   assign load_in_range    = (load_addr[31:AW+2] == '0);
   assign unused_load_lsbs = ^load_addr[1:0];

   // Read data for the accepted request; zero for bubbles and bad ranges.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      req_data = '0;
      if (req_acc && req_in_range) begin
         req_data = mem_q[req_idx];
      end
   end

   // Preload write port; active in reset too, out-of-range loads dropped.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values (this is what gives read-before-write).
      if (load_en && load_in_range) begin
         mem_q[load_idx] <= load_data;
      end
   end

   generate
      if (LATENCY == 0) begin : g_comb
         // Zero latency: response is the same-cycle combinational read.
         assign imem.imemresp_val  = req_acc;
         assign imem.imemresp_data = req_data;
      end else begin : g_pipe
         logic        val_q  [LATENCY];
         logic [31:0] data_q [LATENCY];

         // Shift pipeline of (val, data) pairs, all stages advance each cycle.
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < LATENCY; i++) begin
                  val_q[i]  <= 1'b0;
                  data_q[i] <= '0;
               end
            end else begin
               val_q[0]  <= req_acc;
               data_q[0] <= req_data;
               for (int i = 1; i < LATENCY; i++) begin
                  val_q[i]  <= val_q[i-1];
                  data_q[i] <= data_q[i-1];
               end
            end
         end

         assign imem.imemresp_val  = val_q[LATENCY-1];
         assign imem.imemresp_data = data_q[LATENCY-1];
      end
   endgenerate

   // Sticky error: set by any accepted bad fetch, cleared only by reset.
   always_comb begin
      err_d = err_q;
      if (req_acc && (!req_in_range || req_misaligned)) begin
         err_d = 1'b1;
      end
   end

   // Error flag register; not delayed by the response pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;

`ifdef IMEM_REQ_COUNT_EN
   logic [31:0] req_count_q;
   logic [31:0] req_count_d;

   // Count every accepted request; wraps naturally at 32 bits.
   always_comb begin
      req_count_d = req_count_q + {31'b0, req_acc};
   end

   // Request counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_count_q <= '0;
      end else begin
         req_count_q <= req_count_d;
      end
   end

   assign req_count = req_count_q;
`else
   assign req_count = '0;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: four instances (LATENCY 0..3, the last with
// WORDS=16) share one stimulus stream; a reference model pushes expected
// responses into per-instance queues and a negedge monitor pops and compares.
module tb_imem_responder;

   localparam int NDUT = 4;

   typedef struct {
      int          due;
      logic        val;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_val;
   logic [31:0] req_addr;
   logic        load_en;
   logic [31:0] load_addr;
   logic [31:0] load_data;

   logic        rv [NDUT];
   logic [31:0] rd [NDUT];
   logic        er [NDUT];
   logic [31:0] rc [NDUT];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   bit          mon_en = 1'b0;

   logic [31:0] mem_m   [NDUT][4096];
   logic        err_m   [NDUT];
   logic        err_vis [NDUT];
   logic [31:0] cnt_m;
   logic [31:0] cnt_vis;
   exp_t        sbq     [NDUT][$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   imem_responder_if if0 ();
   imem_responder_if if1 ();
   imem_responder_if if2 ();
   imem_responder_if if3 ();

   assign if0.imemreq_val = req_val;  assign if0.imemreq_addr = req_addr;
   assign if1.imemreq_val = req_val;  assign if1.imemreq_addr = req_addr;
   assign if2.imemreq_val = req_val;  assign if2.imemreq_addr = req_addr;
   assign if3.imemreq_val = req_val;  assign if3.imemreq_addr = req_addr;

   assign rv[0] = if0.imemresp_val;  assign rd[0] = if0.imemresp_data;
   assign rv[1] = if1.imemresp_val;  assign rd[1] = if1.imemresp_data;
   assign rv[2] = if2.imemresp_val;  assign rd[2] = if2.imemresp_data;
   assign rv[3] = if3.imemresp_val;  assign rd[3] = if3.imemresp_data;

   imem_responder #(.WORDS(256), .LATENCY(0)) dut0 (
      .clk(clk), .rst(rst), .imem(if0), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .err(er[0]), .req_count(rc[0]));
   imem_responder #(.WORDS(256), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .imem(if1), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .err(er[1]), .req_count(rc[1]));
   imem_responder #(.WORDS(256), .LATENCY(2)) dut2 (
      .clk(clk), .rst(rst), .imem(if2), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .err(er[2]), .req_count(rc[2]));
   imem_responder #(.WORDS(16), .LATENCY(3)) dut3 (
      .clk(clk), .rst(rst), .imem(if3), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .err(er[3]), .req_count(rc[3]));

   function automatic int words_of(input int k);
      return (k == 3) ? 16 : 256;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: one call per clock cycle with that cycle's inputs.
   task automatic model_step(input logic r, input logic v, input logic [31:0] a,
                             input logic le, input logic [31:0] la, input logic [31:0] ld);
      exp_t e;
      bit   inr;
      cnt_vis = cnt_m;
      for (int k = 0; k < NDUT; k++) begin
         err_vis[k] = err_m[k];
         if (r) begin
            // Reset discards everything not already on the output this cycle.
            while (sbq[k].size() > 0 && sbq[k][$].due > cyc) void'(sbq[k].pop_back());
            err_m[k] = 1'b0;
         end else begin
            inr    = (a < 32'(words_of(k) * 4));
            e.due  = cyc + k;
            e.val  = v;
            e.data = (v && inr) ? mem_m[k][a[13:2]] : 32'h0;
            sbq[k].push_back(e);
            if (v && (!inr || a[1:0] != 2'b00)) err_m[k] = 1'b1;
         end
         // Load applied after the fetch read: read-before-write.
         if (le && la < 32'(words_of(k) * 4)) mem_m[k][la[13:2]] = ld;
      end
      if (r) cnt_m = 32'h0;
      else if (v) cnt_m = cnt_m + 32'h1;
   endtask

   task automatic drive(input logic r, input logic v, input logic [31:0] a,
                        input logic le, input logic [31:0] la, input logic [31:0] ld);
      @(posedge clk);
      #1;
      rst       = r;
      req_val   = v;
      req_addr  = a;
      load_en   = le;
      load_addr = la;
      load_data = ld;
      model_step(r, v, a, le, la, ld);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
   endtask

   function automatic logic [31:0] rand_addr();
      int sel = $urandom_range(0, 9);
      if (sel < 6) return 32'($urandom_range(0, 255)) << 2;
      if (sel < 8) return 32'($urandom_range(0, 1023));
      if (sel == 8) return $urandom;
      case ($urandom_range(0, 3))
         0: return 32'h3FC;
         1: return 32'h400;
         2: return 32'h3C;
         default: return 32'h40;
      endcase
   endfunction

   // Monitor: compare every instance's outputs once per cycle on the negedge.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int k = 0; k < NDUT; k++) begin
            exp_t e;
            while (sbq[k].size() > 0 && sbq[k][0].due < cyc) begin
               e = sbq[k].pop_front();
               check($sformatf("stale_slot_L%0d", k), 32'(e.due), 32'(cyc));
            end
            if (sbq[k].size() > 0 && sbq[k][0].due == cyc) begin
               e = sbq[k].pop_front();
               check($sformatf("resp_val_L%0d", k), 32'(rv[k]), 32'(e.val));
               check($sformatf("resp_data_L%0d", k), rd[k], e.data);
            end else begin
               check($sformatf("resp_val_idle_L%0d", k), 32'(rv[k]), 32'h0);
               check($sformatf("resp_data_idle_L%0d", k), rd[k], 32'h0);
            end
            check($sformatf("err_L%0d", k), 32'(er[k]), 32'(err_vis[k]));
`ifdef IMEM_REQ_COUNT_EN
            check($sformatf("req_count_L%0d", k), rc[k], cnt_vis);
`else
            check($sformatf("req_count_L%0d", k), rc[k], 32'h0);
`endif
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got time %0t expected < 1000000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_val = 1'b0; req_addr = '0;
      load_en = 1'b0; load_addr = '0; load_data = '0;
      cnt_m = '0; cnt_vis = '0;
      for (int k = 0; k < NDUT; k++) begin
         err_m[k] = 1'b0;
         err_vis[k] = 1'b0;
      end

      // Preload every word under reset.
      for (int i = 0; i < 256; i++) drive(1'b1, 1'b0, 32'h0, 1'b1, 32'(i * 4), $urandom);
      mon_en = 1'b1;

      // Preload and same-cycle fetch at LATENCY 0.
      drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0000_0013);
      drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 32'h00A0_0093);
      drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("preload_word0_L0", rd[0], 32'h0000_0013);
      check("preload_val0_L0", 32'(rv[0]), 32'h1);
      drive(1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("preload_word1_L0", rd[0], 32'h00A0_0093);
      check("preload_err_L0", 32'(er[0]), 32'h0);

      // Back-to-back requests then a bubble.
      drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
      idle(5);

      // Same-cycle load and fetch of one word.
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'h1111_1111);
      drive(1'b0, 1'b1, 32'h10, 1'b1, 32'h10, 32'h2222_2222);
      @(negedge clk);
      check("rbw_old_L0", rd[0], 32'h1111_1111);
      drive(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("rbw_new_L0", rd[0], 32'h2222_2222);
      check("rbw_old_L1", rd[1], 32'h1111_1111);
      idle(4);

      // Out-of-range fetch.
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("oor_val_L0", 32'(rv[0]), 32'h1);
      check("oor_data_L0", rd[0], 32'h0);
      check("oor_err_before_edge", 32'(er[0]), 32'h0);
      idle(1);
      @(negedge clk);
      check("oor_err_after_edge", 32'(er[0]), 32'h1);

      // Misaligned fetch after a fresh reset, then err stays for good fetches.
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b1, 32'h6, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("misaligned_word_L0", rd[0], 32'h00A0_0093);
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 32'(i * 4), 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("err_sticky_L0", 32'(er[0]), 32'h1);
      idle(4);

      // Reset while two requests are in flight at LATENCY 3.
      drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      idle(5);
      drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
      idle(3);
      @(negedge clk);
      check("post_reset_word0_L3", rd[3], 32'h0000_0013);
      idle(2);

      // Request counting: in-reset request, 5 requests, 2 bubbles.
      drive(1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b1, 32'h404, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b1, 32'h9, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b1, 32'hC, 1'b0, 32'h0, 32'h0);
      idle(1);
      @(negedge clk);
`ifdef IMEM_REQ_COUNT_EN
      check("req_count_five", rc[0], 32'h5);
`else
      check("req_count_tied", rc[0], 32'h0);
`endif

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 7), rand_addr(),
               ($urandom_range(0, 4) == 0), rand_addr(), $urandom);
      end
      idle(6);

`ifdef IMEM_REQ_COUNT_EN
      // Counter wrap from all-ones.
      idle(1);
      #1;
      force dut0.req_count_q = 32'hFFFF_FFFF;
      force dut1.req_count_q = 32'hFFFF_FFFF;
      force dut2.req_count_q = 32'hFFFF_FFFF;
      force dut3.req_count_q = 32'hFFFF_FFFF;
      #1;
      release dut0.req_count_q;
      release dut1.req_count_q;
      release dut2.req_count_q;
      release dut3.req_count_q;
      cnt_m   = 32'hFFFF_FFFF;
      cnt_vis = 32'hFFFF_FFFF;
      drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
      idle(1);
      @(negedge clk);
      check("req_count_wrap", rc[0], 32'h0);
      idle(4);
`endif

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
